izh_update_unit: RTL and testbench

- Per-timestep neuron update engine. Sits directly upstream of the neuron state register.
- On `start`, sweeps every neuron tag in order. For each tag it:
  - reads v, u and the synaptic current;
  - computes one Izhikevich Euler step in signed Q8.8 fixed point;
  - applies spike/reset;
  - writes v, u back through the state register's write port.
- Spikes are flagged per tag for the downstream spike router.

---
 rtl/izh_update_if.sv | 29 ++
 rtl/izh_update_unit.sv | 122 ++++++++++++
 tb/tb_izh_update_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/izh_update_if.sv
// Bus between the Izhikevich update engine, the neuron state register,
// the synaptic current source and the spike router.
interface izh_update_if #(
   parameter int unsigned NUMWIDTH = 16,
   parameter int unsigned TAGBITS  = 1
);
   logic                      start;
   logic signed [NUMWIDTH:0]  v_in;
   logic signed [NUMWIDTH:0]  u_in;
   logic signed [NUMWIDTH:0]  i_in;
   logic [TAGBITS-1:0]        tag;
   logic                      write_en;
   logic signed [NUMWIDTH:0]  v_new;
   logic signed [NUMWIDTH:0]  u_new;
   logic                      spike;
   logic                      busy;
   logic                      done;

   // master: the update engine; slave: state register / sequencer side
   modport master (
      input  start, v_in, u_in, i_in,
      output tag, write_en, v_new, u_new, spike, busy, done
   );

   modport slave (
      output start, v_in, u_in, i_in,
      input  tag, write_en, v_new, u_new, spike, busy, done
   );
endinterface

// File: rtl/izh_update_unit.sv
// Per-timestep Izhikevich Euler update in signed Q8.8, swept over all neuron tags.
// Optional IZH_SATURATE_EN: clamp written v/u to 17-bit range instead of wrapping.
module izh_update_unit #(
   parameter int unsigned NUMWIDTH   = 16,
   parameter int unsigned NUMNEURONS = 2,
   parameter int unsigned TAGBITS    = 1,
   parameter int          PA         = 5,
   parameter int          PB         = 51,
   parameter int          PC         = -16640,
   parameter int          PD         = 2048,
   parameter int          K2         = 10,
   parameter int          VPEAK      = 7680
) (
   input logic          clk,
   input logic          asyn_reset_n,
   izh_update_if.master bus
);

   localparam int unsigned W  = NUMWIDTH + 1;
   localparam int unsigned AW = 48;

   localparam logic signed [AW-1:0] K2_W    = AW'(K2);
   localparam logic signed [AW-1:0] PA_W    = AW'(PA);
   localparam logic signed [AW-1:0] PB_W    = AW'(PB);
   localparam logic signed [AW-1:0] PD_W    = AW'(PD);
   localparam logic signed [AW-1:0] VPEAK_W = AW'(VPEAK);
   localparam logic signed [AW-1:0] C5      = 48'sd5;
   localparam logic signed [AW-1:0] C_OFF   = 48'sd35840;
   localparam logic [TAGBITS-1:0]   LAST    = TAGBITS'(NUMNEURONS - 1);
   localparam logic signed [W-1:0]  PC_W    = W'(PC);

   typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

   state_t              state;
   logic signed [W-1:0] v_r, u_r, i_r;

   logic signed [AW-1:0] vx, ux, ix, quad, dv, vw, du, uw;
   logic                 spike_c;

   // Reduce a wide intermediate to a 17-bit state word
   function automatic logic signed [W-1:0] fit(input logic signed [AW-1:0] x);
`ifdef IZH_SATURATE_EN
      logic signed [AW-1:0] hi;
      logic signed [AW-1:0] lo;
      hi = (48'sd1 <<< NUMWIDTH) - 48'sd1;
      lo = -(48'sd1 <<< NUMWIDTH);
      if (x > hi)      fit = W'(hi);
      else if (x < lo) fit = W'(lo);
      else             fit = W'(x);
`else
      fit = W'(x);
`endif
   endfunction

   // One Euler step from the registered operands; spike test on full-width Vw
   always_comb begin
      vx      = AW'(v_r);
      ux      = AW'(u_r);
      ix      = AW'(i_r);
      quad    = (K2_W * ((vx * vx) >>> 8)) >>> 8;
      dv      = quad + C5 * vx + C_OFF - ux + ix;
      vw      = vx + dv;
      du      = (PA_W * (((PB_W * vx) >>> 8) - ux)) >>> 8;
      uw      = ux + du;
      spike_c = (vw >= VPEAK_W);
   end

   always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
         state        <= IDLE;
         v_r          <= '0;
         u_r          <= '0;
         i_r          <= '0;
         bus.tag      <= '0;
         bus.write_en <= 1'b0;
         bus.v_new    <= '0;
         bus.u_new    <= '0;
         bus.spike    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.write_en <= 1'b0;
         bus.done     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= READ;
                  bus.tag  <= '0;
                  bus.busy <= 1'b1;
               end
            end
            READ: begin
               v_r   <= bus.v_in;
               u_r   <= bus.u_in;
               i_r   <= bus.i_in;
               state <= CALC;
            end
            CALC: begin
               bus.v_new    <= spike_c ? PC_W : fit(vw);
               bus.u_new    <= spike_c ? fit(uw + PD_W) : fit(uw);
               bus.spike    <= spike_c;
               bus.write_en <= 1'b1;
               state        <= WRITE;
            end
            WRITE: begin
               if (bus.tag == LAST) begin
                  state    <= DONE;
                  bus.tag  <= '0;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end else begin
                  bus.tag <= bus.tag + TAGBITS'(1);
                  state   <= READ;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_izh_update_unit.sv
// Randomized self-checking bench for izh_update_unit against an integer
// reference of the Izhikevich step; honours IZH_SATURATE_EN like the design.
module tb_izh_update_unit;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   izh_update_if #(.NUMWIDTH(16), .TAGBITS(1)) bus();

   izh_update_unit dut (
      .clk          (clk),
      .asyn_reset_n (rst_n),
      .bus          (bus)
   );

   logic signed [16:0] v_mem [N];
   logic signed [16:0] u_mem [N];
   logic signed [16:0] i_mem [N];

   assign bus.v_in = v_mem[bus.tag];
   assign bus.u_in = u_mem[bus.tag];
   assign bus.i_in = i_mem[bus.tag];

   int checks = 0;
   int errors = 0;

   longint got_v [N];
   longint got_u [N];
   longint got_s [N];

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic longint fit_ref(input longint x);
`ifdef IZH_SATURATE_EN
      if (x > 65535) return 65535;
      if (x < -65536) return -65536;
      return x;
`else
      longint m;
      m = ((x % 131072) + 131072) % 131072;
      if (m >= 65536) m = m - 131072;
      return m;
`endif
   endfunction

   // Reference step in plain 64-bit integer arithmetic
   task automatic model(input longint v, input longint u, input longint i,
                        output longint vn, output longint un, output longint sp);
      longint dv, vw, du, uw;
      dv = ((10 * ((v * v) >>> 8)) >>> 8) + 5 * v + 35840 - u + i;
      vw = v + dv;
      du = (5 * (((51 * v) >>> 8) - u)) >>> 8;
      uw = u + du;
      if (vw >= 7680) begin
         sp = 1; vn = -16640; un = fit_ref(uw + 2048);
      end else begin
         sp = 0; vn = fit_ref(vw); un = fit_ref(uw);
      end
   endtask

   task automatic run_sweep(input string name);
      longint ev [N];
      longint eu [N];
      longint es [N];
      int     widx     = 0;
      int     busy_cnt = 0;
      int     cyc      = 0;
      bit     seen     = 0;
      for (int k = 0; k < N; k++)
         model(longint'(v_mem[k]), longint'(u_mem[k]), longint'(i_mem[k]), ev[k], eu[k], es[k]);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      while (!seen && cyc < 40) begin
         if (bus.busy) busy_cnt++;
         if (bus.write_en) begin
            check({name, "_we_busy"}, longint'(bus.busy), 1);
            if (widx < N) begin
               check({name, "_tag"}, longint'(bus.tag), longint'(widx));
               check({name, "_v"}, longint'(bus.v_new), ev[widx]);
               check({name, "_u"}, longint'(bus.u_new), eu[widx]);
               check({name, "_spike"}, longint'(bus.spike), es[widx]);
               got_v[widx] = longint'(bus.v_new);
               got_u[widx] = longint'(bus.u_new);
               got_s[widx] = longint'(bus.spike);
            end
            widx++;
         end
         if (bus.done) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({name, "_done_seen"}, longint'(seen), 1);
      check({name, "_writes"}, longint'(widx), longint'(N));
      check({name, "_busy_cycles"}, longint'(busy_cnt), longint'(3 * N));
      @(negedge clk);
      check({name, "_done_pulse"}, longint'(bus.done), 0);
   endtask

   function automatic longint rnd(input int span, input int lo);
      return longint'(int'($urandom_range(span)) + lo);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int writes, dones, gap, cyc;
      bit second;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      for (int k = 0; k < N; k++) begin
         v_mem[k] = '0; u_mem[k] = '0; i_mem[k] = '0;
      end
      #1;
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_we", longint'(bus.write_en), 0);
      check("rst_done", longint'(bus.done), 0);
      check("rst_tag", longint'(bus.tag), 0);
      check("rst_vnew", longint'(bus.v_new), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Resting neurons
      for (int k = 0; k < N; k++) begin
         v_mem[k] = -17'sd16640; u_mem[k] = -17'sd3328; i_mem[k] = '0;
      end
      run_sweep("rest");
      for (int k = 0; k < N; k++) begin
         check("rest_v_const", got_v[k], -18422);
         check("rest_u_const", got_u[k], -3328);
      end

      // Spike on tag 0, overflow on tag 1
      v_mem[0] = 17'sd7680; u_mem[0] = '0;          i_mem[0] = '0;
      v_mem[1] = '0;        u_mem[1] = 17'sd65535;  i_mem[1] = -17'sd65536;
      run_sweep("spk_ovf");
      check("spk_s_const", got_s[0], 1);
      check("spk_v_const", got_v[0], -16640);
      check("spk_u_const", got_u[0], 2077);
      check("ovf_s_const", got_s[1], 0);
`ifdef IZH_SATURATE_EN
      check("ovf_v_const", got_v[1], -65536);
`else
      check("ovf_v_const", got_v[1], 35841);
`endif
      check("ovf_u_const", got_u[1], 64255);

      // Random sweeps: alternate full-range and physiological operands
      for (int s = 0; s < 24; s++) begin
         for (int k = 0; k < N; k++) begin
            if (s % 2 == 0) begin
               v_mem[k] = 17'(rnd(131071, -65536));
               u_mem[k] = 17'(rnd(131071, -65536));
               i_mem[k] = 17'(rnd(131071, -65536));
            end else begin
               v_mem[k] = 17'(rnd(28000, -20000));
               u_mem[k] = 17'(rnd(10000, -5000));
               i_mem[k] = 17'(rnd(6000, -3000));
            end
         end
         run_sweep("rand");
      end

      // Reset during CALC of tag 1
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_tag_pre", longint'(bus.tag), 1);
      check("mid_busy_pre", longint'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_busy", longint'(bus.busy), 0);
      check("mid_we", longint'(bus.write_en), 0);
      check("mid_tag", longint'(bus.tag), 0);
      @(negedge clk) rst_n = 1'b1;
      writes = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.write_en || bus.busy) writes++;
      end
      check("post_rst_idle", longint'(writes), 0);

      // start held high: back-to-back sweeps, no dropped/extra writes
      writes = 0; dones = 0; gap = 0; second = 0; cyc = 0;
      @(negedge clk) bus.start = 1'b1;
      while (dones < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.write_en) writes++;
         if (bus.done) dones++;
         if (dones == 1 && !second) begin
            if (bus.busy) begin
               second    = 1;
               bus.start = 1'b0;
            end else gap++;
         end
      end
      bus.start = 1'b0;
      check("held_dones", longint'(dones), 2);
      check("held_writes", longint'(writes), longint'(2 * N));
      check("held_restart_gap", longint'(gap), 2);
      repeat (12) @(negedge clk) if (bus.write_en) writes++;
      check("held_no_third", longint'(writes), longint'(2 * N));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
